// File: rtl/mcu_pkg.sv
// Shared definitions for the MCU core: write-back destination codes,
// SFR addresses of the architectural registers and the write-back FSM states.
package mcu_pkg;

    localparam logic [7:0] ACC_SFR_ADDR = 8'hE0;
    localparam logic [7:0] PSW_SFR_ADDR = 8'hD0;
    localparam logic [7:0] BIT_RAM_BASE = 8'h20;

    localparam logic [2:0] DST_NONE     = 3'd0;
    localparam logic [2:0] DST_ACC      = 3'd1;
    localparam logic [2:0] DST_DIRECT   = 3'd2;
    localparam logic [2:0] DST_INDIRECT = 3'd3;
    localparam logic [2:0] DST_BIT      = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PTR_RD,
        ST_PTR_CAP,
        ST_BIT_RD,
        ST_BIT_CAP,
        ST_WRITE
    } wb_state_e;

endpackage

// File: rtl/wb_bit_map.sv
// Bit-address decode to {byte address, bit position} and single-bit byte merge.
// Purely combinational; shared with the operand-fetch bit read path.
module wb_bit_map
    import mcu_pkg::*;
#(
    parameter logic [7:0] BIT_BASE = BIT_RAM_BASE
) (
    input  logic [7:0] bit_addr,
    input  logic [7:0] byte_in,
    input  logic       bit_val,
    output logic [7:0] byte_addr,
    output logic [2:0] bit_pos,
    output logic [7:0] byte_out
);

    always_comb begin
        // Low half addresses the bit RAM area, high half the bit-addressable SFRs
        if (bit_addr[7]) begin
            byte_addr = {bit_addr[7:3], 3'b000};
        end else begin
            byte_addr = BIT_BASE + {4'h0, bit_addr[6:3]};
        end
        bit_pos           = bit_addr[2:0];
        byte_out          = byte_in;
        byte_out[bit_pos] = bit_val;
    end

endmodule

// File: rtl/mcu_writeback.sv
// Write-back stage: commits result bytes to ACC, PSW, internal RAM (direct,
// indirect via R0/R1) or a single bit, owning the architectural ACC and PSW.
module mcu_writeback
    import mcu_pkg::*;
#(
    parameter logic [7:0] ACC_ADDR = ACC_SFR_ADDR,
    parameter logic [7:0] PSW_ADDR = PSW_SFR_ADDR,
    parameter logic [7:0] BIT_BASE = BIT_RAM_BASE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wb_valid,
    output logic       wb_ready,
    input  logic [7:0] wb_ans,
    input  logic [7:0] wb_psw,
    input  logic       wb_psw_we,
    input  logic [2:0] wb_dst,
    input  logic [7:0] wb_addr,
    output logic [7:0] ram_addr,
    output logic       ram_re,
    input  logic [7:0] ram_rdata,
    output logic       ram_we,
    output logic [7:0] ram_wdata,
    output logic [7:0] acc_q,
    output logic [7:0] psw_q
);

    wb_state_e  state;
    logic [7:0] acc_r;
    logic [7:0] psw_r;
    logic [7:0] ans_q;
    logic [7:0] bit_addr_q;

    logic [7:0] psw_base;
    logic [7:0] map_addr;
    logic [7:0] map_in;
    logic       map_val;
    logic [7:0] map_byte;
    logic [2:0] map_pos;
    logic [7:0] map_out;

    assign wb_ready = (state == ST_IDLE);
    assign acc_q    = acc_r;
    assign psw_q    = {psw_r[7:1], ^acc_r};
    assign psw_base = wb_psw_we ? wb_psw : psw_r;

    // One mapper serves both the accept-edge SFR bit path and the RAM merge in BIT_CAP
    always_comb begin
        map_addr = bit_addr_q;
        map_in   = ram_rdata;
        map_val  = ans_q[0];
        if (state == ST_IDLE) begin
            map_addr = wb_addr;
            map_in   = (map_byte == ACC_ADDR) ? acc_r : psw_base;
            map_val  = wb_ans[0];
        end
    end

    wb_bit_map #(.BIT_BASE(BIT_BASE)) u_bit_map (
        .bit_addr (map_addr),
        .byte_in  (map_in),
        .bit_val  (map_val),
        .byte_addr(map_byte),
        .bit_pos  (map_pos),
        .byte_out (map_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            acc_r      <= '0;
            psw_r      <= '0;
            ans_q      <= '0;
            bit_addr_q <= '0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            ram_re     <= 1'b0;
            ram_we     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    ram_re <= 1'b0;
                    ram_we <= 1'b0;
                    if (wb_valid) begin
                        ans_q      <= wb_ans;
                        bit_addr_q <= wb_addr;
                        if (wb_psw_we) psw_r <= wb_psw;
                        case (wb_dst)
                            DST_ACC: acc_r <= wb_ans;
                            DST_DIRECT: begin
                                if (wb_addr == ACC_ADDR) begin
                                    acc_r <= wb_ans;
                                end else if (wb_addr == PSW_ADDR) begin
                                    psw_r <= wb_ans;
                                end else begin
                                    ram_we    <= 1'b1;
                                    ram_addr  <= wb_addr;
                                    ram_wdata <= wb_ans;
                                    state     <= ST_WRITE;
                                end
                            end
                            DST_INDIRECT: begin
                                ram_re   <= 1'b1;
                                ram_addr <= {3'b000, psw_base[4:3], 2'b00, wb_addr[0]};
                                state    <= ST_PTR_RD;
                            end
                            DST_BIT: begin
                                if (map_byte == ACC_ADDR) begin
                                    acc_r <= map_out;
                                end else if (map_byte == PSW_ADDR) begin
                                    psw_r <= map_out;
                                end else begin
                                    ram_re   <= 1'b1;
                                    ram_addr <= map_byte;
                                    state    <= ST_BIT_RD;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_PTR_RD: begin
                    ram_re <= 1'b0;
                    state  <= ST_PTR_CAP;
                end
                ST_PTR_CAP: begin
                    ram_addr  <= ram_rdata;
                    ram_wdata <= ans_q;
                    ram_we    <= 1'b1;
                    state     <= ST_WRITE;
                end
                ST_BIT_RD: begin
                    ram_re <= 1'b0;
                    state  <= ST_BIT_CAP;
                end
                ST_BIT_CAP: begin
                    ram_addr  <= map_byte;
                    ram_wdata <= map_out;
                    ram_we    <= 1'b1;
                    state     <= ST_WRITE;
                end
                ST_WRITE: begin
                    ram_we <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
